// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_t;

  localparam int                   REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO  = 5'd0;

  // A load in E whose destination is read by the instruction in D.
  // x0 is hard-wired to zero, so it can never create a dependency.
  function automatic logic load_use(
    input logic                 is_load,
    input logic                 reg_write,
    input logic [REG_IDX_W-1:0] rd_e,
    input logic [REG_IDX_W-1:0] rs1_d,
    input logic [REG_IDX_W-1:0] rs2_d
  );
    return is_load & reg_write & (rd_e != REG_ZERO) &
           ((rd_e == rs1_d) | (rd_e == rs2_d));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Single saturating event counter; clears on reset and sticks at all-ones.
module hazard_perf_cnt
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: advance on an event unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Producer-side hazard control for the F-D-E-M-WB pipeline: load-use
// bubbles, branch flushes, and a data-memory wait FSM with timeout/halt.
// Build option: define HAZARD_PERF_CNT_EN to add StallCnt/FlushCnt outputs.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] Rs1_D,
  input  logic [REG_IDX_W-1:0] Rs2_D,
  input  logic [REG_IDX_W-1:0] RD_E,
  input  logic                 RegWriteE,
  input  logic                 ResultSrcE0,
  input  logic                 PCSrcE,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]     StallCnt,
  output logic [CNT_W-1:0]     FlushCnt,
`endif
  output logic                 MemErr
);

  localparam int               TMR_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  // Reject configurations the timer cannot represent.
  if (MEM_TIMEOUT < 2) begin : g_bad_timeout
    $error("hazard_stall_ctrl: MEM_TIMEOUT must be >= 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_stall_ctrl: CNT_W must be >= 1");
  end

  hz_state_t        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             mem_err_q, mem_err_d;

  logic lu;       // load-use dependency between E and D
  logic mem_hold; // freeze F/D/E/M and bubble WB this cycle
  logic haz_eval; // apply branch / load-use rules this cycle

  assign lu = load_use(ResultSrcE0, RegWriteE, RD_E, Rs1_D, Rs2_D);

  // Next-state logic: memory wait entry, release, timeout and halt.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    mem_err_d = mem_err_q;
    mem_hold  = 1'b0;
    haz_eval  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          mem_hold = 1'b1;
          timer_d  = TMR_W'(1);
          state_d  = MEM_WAIT;
        end else begin
          haz_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          // Hazards held in E during the wait are handled on release.
          haz_eval = 1'b1;
          timer_d  = '0;
          state_d  = RUN;
        end else if (timer_q == TMR_LAST) begin
          mem_hold  = 1'b1;
          mem_err_d = 1'b1;
          state_d   = HALT;
        end else begin
          mem_hold = 1'b1;
          timer_d  = timer_q + 1'b1;
        end
      end
      HALT: begin
        mem_hold = 1'b1;
      end
      default: begin
        state_d = RUN;
        timer_d = '0;
      end
    endcase
  end

  // Output decode; everything is quiet while reset is asserted.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!rst) begin
      if (mem_hold) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (haz_eval) begin
        if (PCSrcE) begin
          // Taken branch squashes D and E; any load-use there is moot.
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lu) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    end
  end

  // State, timer and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      timer_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign MemErr = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (StallF),
    .cnt (StallCnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (FlushD),
    .cnt (FlushCnt)
  );
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed table, hand sequences for the
// memory wait / timeout / halt corners, then random stimulus vs a model.
module tb_hazard_stall_ctrl;

  localparam int TMO   = 4;
  localparam int CNT_W = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, RD_E;
  logic       RegWriteE, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] StallCnt, FlushCnt;
`endif

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_E(RD_E),
    .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
`ifdef HAZARD_PERF_CNT_EN
    .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
    .MemErr(MemErr)
  );

  // Output vector order: {SF,SD,SE,SM,FD,FE,FW,ERR}
  localparam logic [7:0] V_NONE = 8'b0000_0000;
  localparam logic [7:0] V_LU   = 8'b1100_0100;
  localparam logic [7:0] V_BR   = 8'b0000_1100;
  localparam logic [7:0] V_MEM  = 8'b1111_0010;
  localparam logic [7:0] V_HALT = 8'b1111_0011;

  int tests = 0;
  int fails = 0;

  // Behavioural model: memory wait tracked as "cycles stalled so far".
  bit m_waiting = 0;
  int m_stalled = 0;
  bit m_halt    = 0;
  bit m_err     = 0;
  int m_scnt    = 0;
  int m_fcnt    = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic ld, input logic pc,
                        input logic req, input logic rdy);
    Rs1_D = rs1; Rs2_D = rs2; RD_E = rd; RegWriteE = rw; ResultSrcE0 = ld;
    PCSrcE = pc; MemReqM = req; MemReadyM = rdy;
  endtask

  // One cycle: predict, sample mid-cycle, compare, advance model and clock.
  task automatic step(input string nm, output logic [7:0] got);
    logic [7:0] exp;
    bit blocked, lu;
    int sc, fc;
    lu = ResultSrcE0 && RegWriteE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
    blocked = m_halt || (m_waiting ? !MemReadyM : (MemReqM && !MemReadyM));
    exp = V_NONE;
    if (!rst) begin
      if (blocked)     exp = V_MEM;
      else if (PCSrcE) exp = V_BR;
      else if (lu)     exp = V_LU;
    end
    exp[0] = m_err;
    #4;
    got = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr};
    check(nm, 32'(got), 32'(exp));
`ifdef HAZARD_PERF_CNT_EN
    check({nm, "_scnt"}, 32'(StallCnt), 32'(m_scnt));
    check({nm, "_fcnt"}, 32'(FlushCnt), 32'(m_fcnt));
`endif
    sc = m_scnt + (exp[7] ? 1 : 0);
    fc = m_fcnt + (exp[3] ? 1 : 0);
    m_scnt = (sc > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : sc;
    m_fcnt = (fc > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : fc;
    if (rst) begin
      m_waiting = 0; m_stalled = 0; m_halt = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
    end else if (!m_halt) begin
      if (blocked) begin
        m_waiting = 1;
        m_stalled++;
        if (m_stalled == TMO) begin m_halt = 1; m_err = 1; end
      end else begin
        m_waiting = 0;
        m_stalled = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       rw, ld, pc;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];
  logic [7:0] got;

  initial begin
    tbl[0] = '{5'd0,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, V_LU};   // load-use on rs2
    tbl[1] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, V_NONE}; // bubble follows
    tbl[2] = '{5'd0,  5'd9,  5'd0,  1'b1, 1'b1, 1'b0, V_NONE}; // x0 never hazards
    tbl[3] = '{5'd5,  5'd3,  5'd5,  1'b1, 1'b1, 1'b1, V_BR};   // branch beats load-use
    tbl[4] = '{5'd5,  5'd1,  5'd5,  1'b0, 1'b1, 1'b0, V_NONE}; // no regwrite
    tbl[5] = '{5'd5,  5'd1,  5'd5,  1'b1, 1'b0, 1'b0, V_NONE}; // not a load
    tbl[6] = '{5'd3,  5'd4,  5'd7,  1'b1, 1'b1, 1'b0, V_NONE}; // no match
    tbl[7] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, V_BR};   // plain branch
    tbl[8] = '{5'd31, 5'd2,  5'd31, 1'b1, 1'b1, 1'b0, V_LU};   // load-use on rs1
    tbl[9] = '{5'd12, 5'd12, 5'd12, 1'b1, 1'b1, 1'b0, V_LU};   // both sources

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    step("reset_quiet", got);
    set_in(5, 5, 5, 1, 1, 1, 1, 0);
    step("reset_masks_all", got);
    check("reset_masks_all_k", 32'(got), 32'(V_NONE));
    rst = 1'b0;

    // Directed table, all in RUN with no memory access.
    foreach (tbl[i]) begin
      set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rw, tbl[i].ld, tbl[i].pc, 0, 0);
      step($sformatf("tbl%0d", i), got);
      check($sformatf("tbl%0d_k", i), 32'(got), 32'(tbl[i].exp));
    end

    // Same-cycle ready: no stall.
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    step("mem_hit", got);
    check("mem_hit_k", 32'(got), 32'(V_NONE));

    // Three wait cycles, load-use held in E is only acted on at release.
    for (int i = 0; i < 3; i++) begin
      set_in(5, 0, 5, 1, 1, 0, 1, 0);
      step($sformatf("wait%0d", i), got);
      check($sformatf("wait%0d_k", i), 32'(got), 32'(V_MEM));
    end
    set_in(5, 0, 5, 1, 1, 0, 0, 1);
    step("release_lu", got);
    check("release_lu_k", 32'(got), 32'(V_LU));
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("back_in_run", got);
    check("back_in_run_k", 32'(got), 32'(V_NONE));

    // Ready on the last allowed wait cycle wins over timeout.
    for (int i = 0; i < TMO - 1; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      step($sformatf("edge_wait%0d", i), got);
    end
    set_in(0, 0, 0, 0, 0, 1, 0, 1);
    step("edge_release", got);
    check("edge_release_k", 32'(got), 32'(V_BR));

    // Timeout: TMO stall cycles, then HALT with sticky error.
    for (int i = 0; i < TMO; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      step($sformatf("tmo%0d", i), got);
      check($sformatf("tmo%0d_k", i), 32'(got), 32'(V_MEM));
    end
    set_in(5, 5, 5, 1, 1, 1, 0, 1);
    step("halt_holds", got);
    check("halt_holds_k", 32'(got), 32'(V_HALT));
    step("halt_holds2", got);
    check("halt_holds2_k", 32'(got), 32'(V_HALT));
    rst = 1'b1;
    step("halt_reset", got);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("after_halt", got);
    check("after_halt_k", 32'(got), 32'(V_NONE));

`ifdef HAZARD_PERF_CNT_EN
    // Stall counter saturates at 7 with a 3-bit width.
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      step($sformatf("sat%0d", i), got);
    end
    check("scnt_sat", 32'(StallCnt), 32'd7);
    rst = 1'b1;
    step("sat_reset", got);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("sat_cleared", got);
    check("scnt_clear", 32'(StallCnt), 32'd0);
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 1)));
      step($sformatf("rnd%0d", i), got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
